alu_stim_sequencer: RTL and testbench
=====================================

Name: alu_stim_sequencer

Overview:
- Drives the SWITCHES/BUTTONS side of ALU_top in place of a human operator: loads operand A, then operand B, then the opcode, each with a timed button press.
- After a settle delay it samples LEDS/CLED and returns the result with a one-cycle DONE strobe.
- Sits between a host or self-test controller and ALU_top; used for on-board regression and in benches as the stimulus source.

Parameters:
- SIZEDATA, 8, width of SWITCHES, LEDS and operands
- N_BUTTONS, 3, width of BUTTONS
- SIZEOP, 6, opcode width; driven on SWITCHES[SIZEOP-1:0], upper bits 0
- HOLD_CYCLES, 4, cycles a load button is held high (>=1)
- GAP_CYCLES, 2, cycles all buttons are low after each press (>=1)
- SETTLE_CYCLES, 2, cycles between the last gap and capture (>=1)

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-low reset
- START  in  1  request strobe; sampled only in IDLE
- OP_A  in  SIZEDATA  operand A
- OP_B  in  SIZEDATA  operand B
- OPCODE  in  SIZEOP  ALU operation
- SWITCHES  out  SIZEDATA  to ALU_top SWITCHES
- BUTTONS  out  N_BUTTONS  to ALU_top BUTTONS; [0]=load A, [1]=load B, [2]=load op
- LEDS  in  SIZEDATA  from ALU_top LEDS
- CLED  in  1  from ALU_top carry LED
- RESULT  out  SIZEDATA  captured LEDS
- CARRY  out  1  captured CLED
- BUSY  out  1  high from the cycle after START acceptance through the DONE cycle
- DONE  out  1  one-cycle strobe when RESULT/CARRY are valid

Behaviour:
- Clocking/reset: single clock, CLK. Reset is synchronous and active-low on RESET; one clock domain.
- Reset values: state IDLE; SWITCHES=0, BUTTONS=0, RESULT=0, CARRY=0, BUSY=0, DONE=0; counter=0. RESET low mid-sequence aborts on the next edge: buttons drop to 0 immediately and no DONE is issued.
- Registered outputs: all outputs are registered; no combinational path from inputs to outputs.
- Request capture: START sampled high in IDLE latches OP_A, OP_B and OPCODE into internal registers. Later input changes do not affect the running sequence.
- START while BUSY: ignored, not queued.
- State machine (counter reloads on every transition):
  - IDLE -> LOAD_A: SWITCHES=A, BUTTONS=001 for HOLD_CYCLES.
  - LOAD_A -> GAP_A: BUTTONS=000, SWITCHES held, for GAP_CYCLES.
  - GAP_A -> LOAD_B: SWITCHES=B, BUTTONS=010 for HOLD_CYCLES.
  - LOAD_B -> GAP_B: GAP_CYCLES.
  - GAP_B -> LOAD_OP: SWITCHES={0,OPCODE}, BUTTONS=100 for HOLD_CYCLES.
  - LOAD_OP -> GAP_OP: GAP_CYCLES.
  - GAP_OP -> SETTLE: SETTLE_CYCLES.
  - SETTLE -> DONE_ST: RESULT<=LEDS, CARRY<=CLED on the last SETTLE edge; DONE=1 and BUSY=1 for exactly one cycle.
  - DONE_ST -> IDLE.
- Switch/button ordering: SWITCHES changes on the same edge that a button rises and never while a button is high. Only one BUTTONS bit is ever high.
- Latency with defaults: DONE is high in cycle 21 after the START-sampling edge (1 + 3x4 + 3x2 + 2). The general form is 1 + 3*HOLD_CYCLES + 3*GAP_CYCLES + SETTLE_CYCLES.
- Back-to-back requests: START high in the DONE_ST cycle is ignored; the earliest acceptance is the following IDLE cycle.
- Counter: width clog2(max(HOLD_CYCLES, GAP_CYCLES, SETTLE_CYCLES))+1. It counts down to 1, then transitions, with no wrap beyond the reload.
- RESULT/CARRY: hold their value until the next capture.

Decomposition:
- Shared package alu_pkg holds:
  - state encoding for IDLE, LOAD_A, GAP_A, LOAD_B, GAP_B, LOAD_OP, GAP_OP, SETTLE, DONE_ST;
  - button index constants BTN_A=0, BTN_B=1, BTN_OP=2;
  - opcode constants shared with ALU_top (ADD=6'b100000, SUB=6'b100010, AND=6'b100100, OR=6'b100101, XOR=6'b100110, SRA=6'b000011, SRL=6'b000010, NOR=6'b100111).
- One sub-module is natural: phase_timer, a loadable down-counter with a "last" flag, used for the hold, gap and settle phases.

Test Plan:
- Reset: RESET=0 for 3 cycles with START=1 -> all outputs 0, BUSY stays 0; release -> IDLE, no DONE.
- ADD against ALU_top: A=8'h05, B=8'h03, OPCODE=ADD -> BUTTONS 001/010/100 each high 4 cycles with 2-cycle gaps. SWITCHES=05, 03, 20 in turn. DONE in cycle 21 with RESULT=8'h08, CARRY=0.
- Carry: A=8'hFF, B=8'h01, ADD -> RESULT=8'h00, CARRY=1. A second run with SUB, A=8'h03, B=8'h05 -> RESULT=8'hFE.
- START while BUSY: pulse START at cycle 5 with different operands -> ignored. Exactly one DONE; RESULT matches the first request. Operands changed mid-run have no effect.
- Abort: RESET low during LOAD_B -> BUTTONS=0 next cycle, no DONE. A fresh START after release completes normally in 21 cycles.
- Parameter sweep: HOLD_CYCLES=1, GAP_CYCLES=1, SETTLE_CYCLES=1 -> DONE in cycle 8. No two BUTTONS bits are ever high together, and SWITCHES never changes while any button is high (assertion-checked).

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU stimulus sequencer: phase encoding,
// button indices and the opcode set understood by ALU_top.
package alu_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LOAD_A,
        GAP_A,
        LOAD_B,
        GAP_B,
        LOAD_OP,
        GAP_OP,
        SETTLE,
        DONE_ST
    } seq_state_e;

    localparam int BTN_A  = 0;
    localparam int BTN_B  = 1;
    localparam int BTN_OP = 2;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam int         OP_NOR_I = 6'b100111;
    localparam logic [5:0] OP_NOR = OP_NOR_I[5:0];

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that times one sequencer phase; last_o flags the
// final cycle of the phase so the owner can transition and reload.
module phase_timer #(
    parameter int WIDTH = 3
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             last_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // NOTE: count_d gets a default before any branch so no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q > WIDTH'(1)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last_o = (count_q == WIDTH'(1));

endmodule

// File: rtl/alu_stim_sequencer.sv
// Plays operator for ALU_top: loads A, B and the opcode with timed button
// presses, waits for the result to settle, then captures LEDS/CLED.
module alu_stim_sequencer
    import alu_pkg::*;
#(
    parameter int SIZEDATA      = 8,
    parameter int N_BUTTONS     = 3,
    parameter int SIZEOP        = 6,
    parameter int HOLD_CYCLES   = 4,
    parameter int GAP_CYCLES    = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 START,
    input  logic [SIZEDATA-1:0]  OP_A,
    input  logic [SIZEDATA-1:0]  OP_B,
    input  logic [SIZEOP-1:0]    OPCODE,
    output logic [SIZEDATA-1:0]  SWITCHES,
    output logic [N_BUTTONS-1:0] BUTTONS,
    input  logic [SIZEDATA-1:0]  LEDS,
    input  logic                 CLED,
    output logic [SIZEDATA-1:0]  RESULT,
    output logic                 CARRY,
    output logic                 BUSY,
    output logic                 DONE
);

    localparam int CNT_W = $clog2(max3(HOLD_CYCLES, GAP_CYCLES, SETTLE_CYCLES)) + 1;

    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LD    = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES);

    localparam logic [N_BUTTONS-1:0] PRESS_A  = N_BUTTONS'(1) << BTN_A;
    localparam logic [N_BUTTONS-1:0] PRESS_B  = N_BUTTONS'(1) << BTN_B;
    localparam logic [N_BUTTONS-1:0] PRESS_OP = N_BUTTONS'(1) << BTN_OP;

    seq_state_e        state_q;
    logic [SIZEDATA-1:0] b_q;
    logic [SIZEOP-1:0]   op_q;

    logic              phase_last;
    logic              timer_load;
    logic [CNT_W-1:0]  timer_val;

    phase_timer #(
        .WIDTH (CNT_W)
    ) u_phase_timer (
        .CLK        (CLK),
        .RESET      (RESET),
        .load_i     (timer_load),
        .load_val_i (timer_val),
        .last_o     (phase_last)
    );

    // The timer reloads with the length of whichever phase is entered next.
    always_comb begin
        timer_load = 1'b0;
        timer_val  = '0;
        unique case (state_q)
            IDLE: begin
                timer_load = START;
                timer_val  = HOLD_LD;
            end
            LOAD_A, LOAD_B, LOAD_OP: begin
                timer_load = phase_last;
                timer_val  = GAP_LD;
            end
            GAP_A, GAP_B: begin
                timer_load = phase_last;
                timer_val  = HOLD_LD;
            end
            GAP_OP: begin
                timer_load = phase_last;
                timer_val  = SETTLE_LD;
            end
            SETTLE: begin
                timer_load = phase_last;
            end
            DONE_ST: begin
                timer_load = 1'b1;
            end
            default: begin
                timer_load = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q  <= IDLE;
            b_q      <= '0;
            op_q     <= '0;
            SWITCHES <= '0;
            BUTTONS  <= '0;
            RESULT   <= '0;
            CARRY    <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
        end else begin
            DONE <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (START) begin
                        b_q      <= OP_B;
                        op_q     <= OPCODE;
                        SWITCHES <= OP_A;
                        BUTTONS  <= PRESS_A;
                        BUSY     <= 1'b1;
                        state_q  <= LOAD_A;
                    end
                end
                LOAD_A: begin
                    if (phase_last) begin
                        BUTTONS <= '0;
                        state_q <= GAP_A;
                    end
                end
                GAP_A: begin
                    if (phase_last) begin
                        SWITCHES <= b_q;
                        BUTTONS  <= PRESS_B;
                        state_q  <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (phase_last) begin
                        BUTTONS <= '0;
                        state_q <= GAP_B;
                    end
                end
                GAP_B: begin
                    if (phase_last) begin
                        SWITCHES <= SIZEDATA'(op_q);
                        BUTTONS  <= PRESS_OP;
                        state_q  <= LOAD_OP;
                    end
                end
                LOAD_OP: begin
                    if (phase_last) begin
                        BUTTONS <= '0;
                        state_q <= GAP_OP;
                    end
                end
                GAP_OP: begin
                    if (phase_last) begin
                        state_q <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (phase_last) begin
                        RESULT  <= LEDS;
                        CARRY   <= CLED;
                        DONE    <= 1'b1;
                        state_q <= DONE_ST;
                    end
                end
                DONE_ST: begin
                    BUSY    <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    BUTTONS <= '0;
                    BUSY    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_stim_sequencer.sv
// Scoreboard bench: a behavioural ALU_top sits behind each sequencer; the
// driver queues hand-computed results and monitors compare on every DONE.
module tb_alu_stim_sequencer;
    import alu_pkg::*;

    typedef struct {
        logic [7:0] res;
        logic       carry;
        int         t0;
        int         lat;
    } exp_t;

    logic       CLK = 1'b0;
    logic       rst_n;
    logic       start, f_start;
    logic [7:0] op_a, op_b, f_op_a, f_op_b;
    logic [5:0] opcode, f_opcode;
    logic [7:0] switches, f_switches, leds, f_leds, result, f_result;
    logic [2:0] buttons, f_buttons;
    logic       cled, f_cled, carry, f_carry, busy, f_busy, done, f_done;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic rst_edge = 1'b0;
    exp_t sb_q[$];
    exp_t fsb_q[$];
    exp_t mon_e, fmon_e;

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        cyc      <= cyc + 1;
        rst_edge <= rst_n;
    end

    alu_stim_sequencer dut (
        .CLK(CLK), .RESET(rst_n), .START(start), .OP_A(op_a), .OP_B(op_b),
        .OPCODE(opcode), .SWITCHES(switches), .BUTTONS(buttons), .LEDS(leds),
        .CLED(cled), .RESULT(result), .CARRY(carry), .BUSY(busy), .DONE(done)
    );

    alu_stim_sequencer #(
        .HOLD_CYCLES(1), .GAP_CYCLES(1), .SETTLE_CYCLES(1)
    ) dut_fast (
        .CLK(CLK), .RESET(rst_n), .START(f_start), .OP_A(f_op_a), .OP_B(f_op_b),
        .OPCODE(f_opcode), .SWITCHES(f_switches), .BUTTONS(f_buttons), .LEDS(f_leds),
        .CLED(f_cled), .RESULT(f_result), .CARRY(f_carry), .BUSY(f_busy), .DONE(f_done)
    );

    // Behavioural stand-in for ALU_top: latches operands on button presses.
    function automatic logic [8:0] alu_f(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            OP_ADD:  return {1'b0, a} + {1'b0, b};
            OP_SUB:  return {1'b0, a} - {1'b0, b};
            OP_AND:  return {1'b0, a & b};
            OP_OR:   return {1'b0, a | b};
            OP_XOR:  return {1'b0, a ^ b};
            OP_NOR:  return {1'b0, ~(a | b)};
            default: return 9'd0;
        endcase
    endfunction

    logic [7:0] m_a = '0, m_b = '0, fm_a = '0, fm_b = '0;
    logic [5:0] m_op = '0, fm_op = '0;

    always @(posedge CLK) begin
        if (buttons[BTN_A])    m_a   <= switches;
        if (buttons[BTN_B])    m_b   <= switches;
        if (buttons[BTN_OP])   m_op  <= switches[5:0];
        if (f_buttons[BTN_A])  fm_a  <= f_switches;
        if (f_buttons[BTN_B])  fm_b  <= f_switches;
        if (f_buttons[BTN_OP]) fm_op <= f_switches[5:0];
    end

    assign {cled, leds}     = alu_f(m_op, m_a, m_b);
    assign {f_cled, f_leds} = alu_f(fm_op, fm_a, fm_b);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: pop one expectation per DONE strobe.
    logic done_prev = 1'b0, f_done_prev = 1'b0;

    always @(negedge CLK) begin
        if (done === 1'b1) begin
            check("busy_in_done", busy, 1);
            check("done_single_cycle", done_prev, 0);
            if (sb_q.size() == 0) begin
                check("unexpected_done", done, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check("result", result, mon_e.res);
                check("carry", carry, mon_e.carry);
                check("latency", cyc - mon_e.t0, mon_e.lat);
            end
        end
        done_prev = (done === 1'b1);
    end

    always @(negedge CLK) begin
        if (f_done === 1'b1) begin
            check("fast_busy_in_done", f_busy, 1);
            if (fsb_q.size() == 0) begin
                check("fast_unexpected_done", f_done, 0);
            end else begin
                fmon_e = fsb_q.pop_front();
                check("fast_result", f_result, fmon_e.res);
                check("fast_carry", f_carry, fmon_e.carry);
                check("fast_latency", cyc - fmon_e.t0, fmon_e.lat);
            end
        end
    end

    // Button/switch invariants for both sequencers.
    logic [7:0] sw_prev = '0, f_sw_prev = '0;
    logic [2:0] bt_prev = '0, f_bt_prev = '0;

    always @(negedge CLK) begin
        if (rst_edge === 1'b1) begin
            check("btn_onehot", $onehot0(buttons), 1);
            check("fast_btn_onehot", $onehot0(f_buttons), 1);
            if (bt_prev != 3'b000)   check("sw_stable_while_btn", switches, sw_prev);
            if (f_bt_prev != 3'b000) check("fast_sw_stable_while_btn", f_switches, f_sw_prev);
        end
        sw_prev   = switches;
        bt_prev   = buttons;
        f_sw_prev = f_switches;
        f_bt_prev = f_buttons;
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op,
                         input logic [7:0] res, input logic c, input bit expect_done);
        exp_t e;
        op_a   = a;
        op_b   = b;
        opcode = op;
        start  = 1'b1;
        e.res   = res;
        e.carry = c;
        e.t0    = cyc;
        e.lat   = 21;
        if (expect_done) sb_q.push_back(e);
        tick();
        start = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || fsb_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check("drain_timeout", sb_q.size() + fsb_q.size(), 0);
        tick();
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [5:0] op;
        logic [7:0] res;
        logic       c;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int   n;
        exp_t fe;
        logic [2:0] eb;
        logic [7:0] es;

        vecs[0] = '{8'h05, 8'h03, OP_ADD, 8'h08, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, OP_ADD, 8'h00, 1'b1};
        vecs[2] = '{8'h03, 8'h05, OP_SUB, 8'hFE, 1'b1};
        vecs[3] = '{8'hF0, 8'h3C, OP_XOR, 8'hCC, 1'b0};

        rst_n = 1'b0; start = 1'b1; op_a = 8'hAA; op_b = 8'h55; opcode = OP_ADD;
        f_start = 1'b0; f_op_a = '0; f_op_b = '0; f_opcode = '0;

        // Reset held with START high: everything stays quiet.
        tick();
        for (int i = 0; i < 3; i++) begin
            check("rst_switches", switches, 0);
            check("rst_buttons", buttons, 0);
            check("rst_result", result, 0);
            check("rst_carry", carry, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            tick();
        end
        start = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_busy", busy, 0);
            check("post_rst_buttons", buttons, 0);
        end

        // First ADD with a full button/switch trace.
        issue(vecs[0].a, vecs[0].b, vecs[0].op, vecs[0].res, vecs[0].c, 1'b1);
        for (int k = 1; k <= 20; k++) begin
            eb = (k <= 4)  ? 3'b001 : (k <= 6)  ? 3'b000 : (k <= 10) ? 3'b010 :
                 (k <= 12) ? 3'b000 : (k <= 16) ? 3'b100 : 3'b000;
            es = (k <= 6) ? 8'h05 : (k <= 12) ? 8'h03 : 8'h20;
            check("btn_trace", buttons, eb);
            check("sw_trace", switches, es);
            check("busy_trace", busy, 1);
            check("done_early", done, 0);
            tick();
        end
        drain(40);

        for (int v = 1; v < 4; v++) begin
            issue(vecs[v].a, vecs[v].b, vecs[v].op, vecs[v].res, vecs[v].c, 1'b1);
            drain(40);
        end

        // START while busy is ignored; operand changes mid-run have no effect.
        issue(8'h0F, 8'hF5, OP_AND, 8'h05, 1'b0, 1'b1);
        tick(); tick(); tick();
        op_a = 8'h11; op_b = 8'h22; opcode = OP_ADD; start = 1'b1;
        tick();
        start = 1'b0; op_a = 8'h77; op_b = 8'h99; opcode = OP_OR;
        drain(40);
        for (int i = 0; i < 5; i++) tick();
        check("result_hold", result, 8'h05);
        check("idle_busy", busy, 0);

        // Abort during LOAD_B.
        issue(8'h09, 8'h04, OP_SUB, 8'h05, 1'b0, 1'b0);
        n = 0;
        while (buttons !== 3'b010 && n < 30) begin
            tick();
            n++;
        end
        check("abort_reached_load_b", buttons, 3'b010);
        rst_n = 1'b0;
        tick();
        check("abort_buttons", buttons, 0);
        check("abort_busy", busy, 0);
        check("abort_switches", switches, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 25; i++) tick();
        check("abort_result_cleared", result, 0);
        issue(8'h12, 8'h34, OP_ADD, 8'h46, 1'b0, 1'b1);
        drain(40);

        // Minimum-length phases on the second instance.
        f_op_a = 8'h05; f_op_b = 8'h03; f_opcode = OP_ADD; f_start = 1'b1;
        fe.res = 8'h08; fe.carry = 1'b0; fe.t0 = cyc; fe.lat = 8;
        fsb_q.push_back(fe);
        tick();
        f_start = 1'b0;
        check("fast_btn_first", f_buttons, 3'b001);
        drain(20);
        f_op_a = 8'h80; f_op_b = 8'h80; f_opcode = OP_ADD; f_start = 1'b1;
        fe.res = 8'h00; fe.carry = 1'b1; fe.t0 = cyc; fe.lat = 8;
        fsb_q.push_back(fe);
        tick();
        f_start = 1'b0;
        drain(20);

        for (int i = 0; i < 3; i++) tick();
        check("queues_empty", sb_q.size() + fsb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
